// File: rtl/burst_responder_pkg.sv
// Shared types and sizing helpers for the burst responder.
package burst_pkg;

    typedef enum logic [2:0] {FILL, READY, ACK, STREAM, DONE} burst_state_t;

    localparam int BURST_BEATS_DEFAULT = 4;

    // Counters must hold 0..BEATS inclusive.
    function automatic int burst_cnt_w(input int beats);
        return $clog2(beats + 1);
    endfunction

    function automatic int burst_addr_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/burst_responder_if.sv
// Source (valid/ready) and consumer (req/ack/dv/taken/done) signals of the burst responder.
interface burst_responder_if #(
    parameter int DATA_W = 32
) ();
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              req;
    logic              ack;
    logic              dv;
    logic [DATA_W-1:0] data;
    logic              taken;
    logic              done;

    modport slave (
        input  src_valid, src_data, req, taken,
        output src_ready, ack, dv, data, done
    );

    modport master (
        output src_valid, src_data, req, taken,
        input  src_ready, ack, dv, data, done
    );
endinterface

// File: rtl/burst_responder_buf.sv
// Burst word buffer: one register per beat, single write port, asynchronous read.
module burst_buf #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (we && (waddr == ADDR_W'(gi))) begin
                    r_mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/burst_responder.sv
// Prefetches BEATS words from a valid/ready source, then serves them as one req/ack/dv/taken/done burst.
// Optional macro BURST_RESPONDER_ASSERT_EN compiles in protocol assertions.
module burst_responder
    import burst_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BEATS  = BURST_BEATS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    burst_responder_if.slave   bus
);
    localparam int CNT_W  = burst_cnt_w(BEATS);
    localparam int ADDR_W = burst_addr_w(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    burst_state_t      r_state;
    burst_state_t      w_state_next;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  r_rcnt;
    logic              r_src_ready;
    logic              w_we;
    logic              w_take;
    logic [DATA_W-1:0] w_rdata;

    // r_src_ready is only ever set while in FILL, so it doubles as the fill qualifier.
    assign w_we   = r_src_ready && bus.src_valid;
    assign w_take = (r_state == STREAM) && bus.taken;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_we && (r_wcnt == LAST)) w_state_next = READY;
            READY:   if (bus.req) w_state_next = ACK;
            ACK:     w_state_next = STREAM;
            STREAM:  if (w_take && (r_rcnt == LAST)) w_state_next = DONE;
            DONE:    w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_src_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_src_ready <= (w_state_next == FILL);
            if (r_state == DONE) begin
                r_wcnt <= '0;
                r_rcnt <= '0;
            end else begin
                if (w_we)   r_wcnt <= r_wcnt + 1'b1;
                if (w_take) r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    burst_buf #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wcnt[ADDR_W-1:0]),
        .wdata (bus.src_data),
        .raddr (r_rcnt[ADDR_W-1:0]),
        .rdata (w_rdata)
    );

    assign bus.src_ready = r_src_ready;
    assign bus.ack       = (r_state == ACK);
    assign bus.dv        = (r_state == STREAM);
    assign bus.done      = (r_state == DONE);
    assign bus.data      = w_rdata;

`ifdef BURST_RESPONDER_ASSERT_EN
    // Set by a grant, cleared once the consumer lets req fall; a new grant needs it clear.
    logic r_req_drop_pending;
    always_ff @(posedge clk) begin
        if (rst)               r_req_drop_pending <= 1'b0;
        else if (bus.ack)      r_req_drop_pending <= 1'b1;
        else if (!bus.req)     r_req_drop_pending <= 1'b0;
    end

    a_taken_dv: assert property (@(posedge clk) disable iff (rst) bus.taken |-> bus.dv)
        else $error("taken asserted while dv is low");
    a_req_hold: assert property (@(posedge clk) disable iff (rst) (bus.req && !bus.ack) |=> (bus.req || bus.ack))
        else $error("req dropped before ack");
    a_req_drop: assert property (@(posedge clk) disable iff (rst) bus.ack |-> !r_req_drop_pending)
        else $error("req not deasserted between grants");
    a_ack_single: assert property (@(posedge clk) disable iff (rst) bus.ack |=> !bus.ack)
        else $error("ack longer than one cycle");
    a_done_single: assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done)
        else $error("done longer than one cycle");
    a_done_taken: assert property (@(posedge clk) disable iff (rst) bus.done |-> $past(bus.taken))
        else $error("done without preceding taken");
    a_ack_req: assert property (@(posedge clk) disable iff (rst) bus.ack |-> $past(bus.req))
        else $error("ack without preceding req");
`else
    // Assertions excluded from this build.
`endif

endmodule

// File: tb/tb_burst_responder.sv
// Directed bench for burst_responder with a queue-based reference model checked every cycle.
module tb_burst_responder;
    localparam int DW    = 32;
    localparam int BEATS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    burst_responder_if #(.DATA_W(DW)) bif ();

    burst_responder #(.DATA_W(DW), .BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Stimulus controls
    logic [DW-1:0] src_words[$];
    int            src_idx      = 0;
    bit            valid_toggle = 0;
    bit            req_drive    = 0;
    int            taken_mode   = 0;
    bit            rst_drive    = 1;

    // Observation logs
    logic [DW-1:0] tlog[$];
    int            tcyc[$];
    int            acyc[$];
    int            dcyc[$];

    // Reference model: words accepted so far, words handed out, and which pulse phase is active.
    logic [DW-1:0] m_q[$];
    int            m_sent   = 0;
    bit            m_ack    = 0;
    bit            m_stream = 0;
    bit            m_done   = 0;
    bit            m_fresh  = 0;
    bit            m_live   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_sent   <= 0;
            m_ack    <= 0;
            m_stream <= 0;
            m_done   <= 0;
            m_fresh  <= 1;
            m_live   <= 1;
        end else if (m_live) begin
            if (m_done) begin
                m_done <= 0;
                m_q.delete();
                m_sent <= 0;
            end else if (m_ack) begin
                m_ack    <= 0;
                m_stream <= 1;
            end else if (m_stream) begin
                if (bif.taken) begin
                    m_sent <= m_sent + 1;
                    if (m_sent == BEATS - 1) begin
                        m_stream <= 0;
                        m_done   <= 1;
                    end
                end
            end else if (m_q.size() == BEATS) begin
                if (bif.req) m_ack <= 1;
            end else if (m_fresh) begin
                m_fresh <= 0;
            end else if (bif.src_valid) begin
                m_q.push_back(bif.src_data);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("src_ready", bif.src_ready,
                  (!m_fresh && !m_ack && !m_stream && !m_done && (m_q.size() < BEATS)));
            check("ack", bif.ack, m_ack);
            check("dv", bif.dv, m_stream);
            check("done", bif.done, m_done);
            if (m_stream) check("data", bif.data, m_q[m_sent]);
            if (bif.ack)  acyc.push_back(cyc);
            if (bif.done) dcyc.push_back(cyc);
        end
    end

    task automatic step();
        bit acc;
        acc = bif.src_valid && bif.src_ready && !rst;
        @(negedge clk);
        #1;
        if (acc) src_idx++;
        rst           = rst_drive;
        bif.src_valid = (src_idx < src_words.size()) && (!valid_toggle || (cyc % 2 == 0));
        bif.src_data  = (src_idx < src_words.size()) ? src_words[src_idx] : '0;
        bif.req       = req_drive;
        case (taken_mode)
            0:       bif.taken = 1'b0;
            1:       bif.taken = bif.dv;
            2:       bif.taken = bif.dv && (cyc % 2 == 0);
            default: bif.taken = 1'b1;
        endcase
        if (bif.taken && bif.dv) begin
            tlog.push_back(bif.data);
            tcyc.push_back(cyc);
        end
    endtask

    task automatic clear_logs();
        tlog.delete();
        tcyc.delete();
        acyc.delete();
        dcyc.delete();
    endtask

    task automatic load4(logic [DW-1:0] base);
        src_words.delete();
        for (int i = 0; i < 4; i++) src_words.push_back(base + DW'(i));
        src_idx = 0;
    endtask

    task automatic check_log(string tag, int off, logic [DW-1:0] base);
        if (tlog.size() >= off + 4) begin
            for (int i = 0; i < 4; i++) check(tag, tlog[off + i], base + DW'(i));
        end else begin
            check({tag, "_len"}, tlog.size(), off + 4);
        end
    endtask

    initial begin
        bif.src_valid = 1'b0;
        bif.src_data  = '0;
        bif.req       = 1'b0;
        bif.taken     = 1'b0;

        // Reset state
        repeat (2) step();
        check("rst_src_ready", bif.src_ready, 0);
        check("rst_ack", bif.ack, 0);
        check("rst_dv", bif.dv, 0);
        check("rst_done", bif.done, 0);
        rst_drive = 0;

        // T1: continuous source, req held, taken every beat
        load4(32'hA0);
        req_drive = 1; taken_mode = 1;
        clear_logs();
        repeat (20) step();
        check("t1_len", tlog.size(), 4);
        check_log("t1_data", 0, 32'hA0);
        check("t1_acks", acyc.size(), 1);
        check("t1_dones", dcyc.size(), 1);
        if (acyc.size() == 1 && dcyc.size() == 1 && tcyc.size() == 4) begin
            check("t1_ack_to_done", dcyc[0] - acyc[0], 5);
            check("t1_first_take", tcyc[0] - acyc[0], 1);
            check("t1_take_to_done", dcyc[0] - tcyc[3], 1);
        end

        // T2: taken on alternate cycles
        load4(32'h10);
        taken_mode = 2;
        clear_logs();
        repeat (25) step();
        check_log("t2_data", 0, 32'h10);
        check("t2_dones", dcyc.size(), 1);
        if (tcyc.size() == 4 && dcyc.size() == 1) begin
            check("t2_gap", tcyc[1] - tcyc[0], 2);
            check("t2_take_to_done", dcyc[0] - tcyc[3], 1);
        end

        // T3: toggling source valid, req low
        load4(32'h20);
        valid_toggle = 1; req_drive = 0; taken_mode = 1;
        clear_logs();
        repeat (20) step();
        check("t3_no_ack", acyc.size(), 0);
        check("t3_accepts", src_idx, 4);

        // T4: req after a long idle in READY
        req_drive = 1; valid_toggle = 0;
        repeat (12) step();
        check("t4_acks", acyc.size(), 1);
        check_log("t4_data", 0, 32'h20);

        // T5: reset after two takens aborts the burst
        load4(32'h30);
        clear_logs();
        for (int i = 0; i < 40 && tlog.size() < 2; i++) step();
        check("t5_two_takens", tlog.size(), 2);
        taken_mode = 0; rst_drive = 1;
        step();
        load4(32'hB0);
        rst_drive = 0; taken_mode = 1;
        step();
        check("t5_dv_after_rst", bif.dv, 0);
        check("t5_no_done", dcyc.size(), 0);
        clear_logs();
        repeat (20) step();
        check_log("t5_data", 0, 32'hB0);
        check("t5_dones", dcyc.size(), 1);

        // T6: taken forced high, req held through done, back-to-back bursts
        src_words.delete();
        for (int i = 0; i < 4; i++) src_words.push_back(32'hC0 + DW'(i));
        for (int i = 0; i < 4; i++) src_words.push_back(32'hD0 + DW'(i));
        src_idx = 0;
        taken_mode = 3;
        clear_logs();
        repeat (40) step();
        check_log("t6_data_c", 0, 32'hC0);
        check_log("t6_data_d", 4, 32'hD0);
        check("t6_acks", acyc.size(), 2);
        check("t6_dones", dcyc.size(), 2);
        if (acyc.size() == 2 && dcyc.size() >= 1)
            check("t6_done_to_ack", acyc[1] - dcyc[0], BEATS + 2);
        taken_mode = 0;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/burst_responder.md
Name: burst_responder

Overview:
- Responder side of the req/ack/dv/taken/done burst protocol.
- Prefetches one burst of BEATS words from an upstream valid/ready source into a local buffer.
- Answers a requester's req with a one-cycle ack, then streams the words on dv/data, advancing on taken, and ends with a one-cycle done.
- Sits directly downstream of the data source and upstream of the requesting consumer.

Parameters:
DATA_W, 32, width of each data beat
BEATS, 4, words per burst (>=1); counters are $clog2(BEATS+1) bits

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
src_valid  in  1  upstream word valid
src_data  in  DATA_W  upstream word
src_ready  out  1  block accepts upstream word this cycle
req  in  1  burst request from consumer
ack  out  1  one-cycle grant pulse
dv  out  1  data valid, held for the whole burst
data  out  DATA_W  current beat, stable while dv and !taken
taken  in  1  consumer takes current beat; legal only while dv
done  out  1  one-cycle end-of-burst pulse

Behaviour:
- Reset: state=FILL, counters=0, ack=0, dv=0, done=0, src_ready=0 in the reset cycle. Buffer contents are don't-care.
- Reset mid-burst aborts immediately with no done, and the partially filled or unsent buffer is discarded.
- All outputs are registered or decoded from state only; nothing is combinational from inputs.
- State FILL:
  - src_ready=1.
  - Each cycle with src_valid&&src_ready writes buf[wcnt] and increments wcnt.
  - On the BEATS-th write, go to READY with src_ready=0 from the next cycle.
  - req is ignored in FILL.
- State READY: wait for req=1, then go to ACK. The buffer is held indefinitely.
- State ACK:
  - ack=1 for exactly one cycle; unconditionally go to STREAM.
  - Latency is req seen in READY at cycle t -> ack at t+1 -> dv at t+2.
- State STREAM:
  - dv=1 and data=buf[rcnt].
  - taken increments rcnt.
  - On the BEATS-th taken, go to DONE. dv is continuous from the first to the last taken, even across idle cycles.
- State DONE: dv=0, done=1 for one cycle, rcnt and wcnt cleared; go to FILL.
- Guaranteed properties:
  - ack only when the previous cycle sampled req=1.
  - ack never two cycles in a row.
  - done only the cycle after a taken.
  - done never two cycles in a row.
  - dv=0 whenever done=1.
- Boundary handling:
  - taken while dv=0 is ignored (protocol violation).
  - req held high through DONE does not re-ack until the new burst has been filled and READY sampled.
  - src_valid during non-FILL states is not accepted.
  - BEATS=1: a single taken goes straight to DONE.
  - Back-to-back bursts: minimum gap from done to the next ack is BEATS+2 cycles with src_valid constant high.

Optional Feature:
- Macro BURST_RESPONDER_ASSERT_EN.
- When defined, the block contains concurrent SVA checks, all with disable iff (rst):
  - consumer side: taken|->dv, and req held until ack then deasserted for at least one cycle;
  - own outputs: ack|=>!ack, done|=>!done, done|->$past(taken), and ack|->$past(req).
  - Any failure reports through $error.
- When undefined, no assertion code is compiled and behaviour is identical.

Decomposition:
- Package burst_pkg holds:
  - typedef enum logic [2:0] {FILL, READY, ACK, STREAM, DONE} burst_state_t;
  - localparam BURST_BEATS_DEFAULT=4;
  - a count-width function.
- One sub-module, burst_buf: BEATS x DATA_W register array with a write port (we, waddr, wdata) and an asynchronous read (raddr -> rdata).
- The FSM and counters stay in burst_responder.

Test Plan:
1. Reset, then src_valid=1 with data 0xA0..0xA3, req=1 held -> src_ready high 4 cycles, ack one cycle, dv next cycle, data 0xA0..0xA3 with taken every cycle, done exactly one cycle after 4th taken with dv=0.
2. Taken on alternate cycles -> dv stays 1 across gaps, data holds value until taken, done follows the 4th taken by one cycle.
3. src_valid toggling 1,0,1,0 -> only accepted beats are stored, READY reached after the 4th accept, streamed order matches accept order.
4. req=0 for 10 cycles after READY -> no ack, buffer held; req=1 -> ack next cycle, first beat correct.
5. Reset asserted after 2 takens -> dv=0, done never pulses, state FILL; a fresh burst 0xB0..0xB3 then streams correctly.
6. taken=1 while dv=0 and req held through done -> no counter change, no second ack before refill completes; with BURST_RESPONDER_ASSERT_EN the taken|->dv check fires.
